// File: rtl/multiphase_clock_gen_if.sv
// rtl/multiphase_clock_gen_if.sv - control and phase-output bundle for multiphase_clock_gen
// The master side drives run control; the slave side (the generator) drives phases and status.
interface multiphase_clock_gen_if #(
  parameter int NPHASE = 2,
  parameter int CNT_W  = 16
);
  logic              active;
  logic              mode;
  logic              step;
  logic [NPHASE-1:0] phi;
  logic              cycle_start;
  logic              busy;
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    output active, mode, step,
    input  phi, cycle_start, busy, cycle_count
  );

  modport slave (
    input  active, mode, step,
    output phi, cycle_start, busy, cycle_count
  );
endinterface

// File: rtl/multiphase_clock_gen.sv
// rtl/multiphase_clock_gen.sv - non-overlapping multiphase clock generator
// Each phase is HIGH_LEN clocks high followed by GAP_LEN all-low clocks; free-run or single-step.
module multiphase_clock_gen #(
  parameter int NPHASE   = 2,
  parameter int HIGH_LEN = 8,
  parameter int GAP_LEN  = 2,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  multiphase_clock_gen_if.slave   bus
);

  localparam int TMAX = (HIGH_LEN > GAP_LEN) ? HIGH_LEN : GAP_LEN;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int PW   = $clog2(NPHASE);

  localparam logic [TW-1:0] HIGH_LAST  = TW'(HIGH_LEN - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_LEN - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(NPHASE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [NPHASE-1:0] phi_q, phi_d;
  logic              cycle_start_q, cycle_start_d;
  logic              busy_q, busy_d;
  logic              start_req;
  logic              continue_req;

  // In single-step mode only step starts a cycle; in free-run only active does.
  always_comb begin
    start_req    = bus.mode ? bus.step : bus.active;
    continue_req = !bus.mode && bus.active;
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    tick_d  = tick_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d = HIGH;
          phase_d = '0;
          tick_d  = '0;
        end
      end
      HIGH: begin
        if (tick_q == HIGH_LAST) begin
          state_d = GAP;
          tick_d  = '0;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      GAP: begin
        if (tick_q != GAP_LAST) begin
          tick_d = tick_q + 1'b1;
        end else if (phase_q != PHASE_LAST) begin
          state_d = HIGH;
          phase_d = phase_q + 1'b1;
          tick_d  = '0;
        end else begin
          // Cycle boundary: the only place mode/active are looked at once running.
          count_d = count_q + 1'b1;
          phase_d = '0;
          tick_d  = '0;
          state_d = continue_req ? HIGH : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
        tick_d  = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies track the state flops exactly.
  always_comb begin
    phi_d         = '0;
    if (state_d == HIGH) begin
      phi_d = NPHASE'(1) << phase_d;
    end
    busy_d        = (state_d != IDLE);
    cycle_start_d = (state_d == HIGH) && (phase_d == '0) && (tick_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      tick_q        <= '0;
      count_q       <= '0;
      phi_q         <= '0;
      cycle_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      tick_q        <= tick_d;
      count_q       <= count_d;
      phi_q         <= phi_d;
      cycle_start_q <= cycle_start_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.phi         = phi_q;
  assign bus.cycle_start = cycle_start_q;
  assign bus.busy        = busy_q;
  assign bus.cycle_count = count_q;

endmodule

// File: doc/multiphase_clock_gen.md
MULTIPHASE_CLOCK_GEN -- requirements
Module: multiphase_clock_gen

Interface
REQ-001 SHALL have parameter NPHASE, default 2, number of non-overlapping phase outputs (legal range 2..16).
REQ-002 SHALL have parameter HIGH_LEN, default 8, clk cycles each phase stays high (legal ≥1).
REQ-003 SHALL have parameter GAP_LEN, default 2, all-low clk cycles after each phase (legal ≥1).
REQ-004 SHALL have parameter CNT_W, default 16, width of cycle_count.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port active, input, 1, free-run enable (mode=0).
REQ-008 SHALL have port mode, input, 1, 0 = free-run, 1 = single-step.
REQ-009 SHALL have port step, input, 1, single-cycle request (mode=1).
REQ-010 SHALL have port phi, output, NPHASE, phase clocks; phi[i] is phase i.
REQ-011 SHALL have port cycle_start, output, 1, one-clk pulse marking the first high clk of phi[0].
REQ-012 SHALL have port busy, output, 1, high while a phase cycle is in progress.
REQ-013 SHALL have port cycle_count, output, CNT_W, number of completed phase cycles.

Function
REQ-014 SHALL implement FSM states IDLE, HIGH, GAP, plus a phase index (0..NPHASE-1) and a tick counter sized for max(HIGH_LEN, GAP_LEN).
REQ-015 SHALL decode phi, busy and cycle_start from registered state only; no combinational path from any input to any output.
REQ-016 SHALL drive phi[i]=1 iff state==HIGH and phase index==i, so at most one phi bit is high in any clk cycle.
REQ-017 SHALL, in IDLE, move to HIGH with phase index 0 and tick 0 when (mode==0 and active==1) or (mode==1 and step==1) is sampled; otherwise stay in IDLE.
REQ-018 SHALL, in HIGH, increment tick each clk; at tick==HIGH_LEN-1, move to GAP with tick 0.
REQ-019 SHALL, in GAP at tick==GAP_LEN-1 with phase index<NPHASE-1, move to HIGH with phase index+1 and tick 0.
REQ-020 SHALL, in GAP at tick==GAP_LEN-1 with phase index==NPHASE-1, increment cycle_count (mod 2^CNT_W), then go to HIGH phase 0 if mode==0 and active==1, else to IDLE.
REQ-021 SHALL give a free-run period of exactly NPHASE*(HIGH_LEN+GAP_LEN) clk cycles with no idle cycle between consecutive cycles.
REQ-022 SHALL assert cycle_start for exactly the first clk of every phi[0] high window.
REQ-023 SHALL assert busy whenever state!=IDLE.
REQ-024 SHALL NOT truncate a cycle when active deasserts mid-cycle; the cycle completes and the FSM stops at the boundary (graceful stop).
REQ-025 SHALL ignore step while busy, step while mode==0, and active while mode==1.
REQ-026 SHALL sample mode changes only at IDLE or at a cycle boundary, never mid-cycle.
REQ-027 SHALL wrap cycle_count from 2^CNT_W-1 to 0 without any flag or stall.

Reset
REQ-028 SHALL, on rst assertion, immediately and asynchronously force state=IDLE, phase index=0, tick=0, phi=0, cycle_start=0, busy=0, cycle_count=0.
REQ-029 SHALL, on reset asserted mid-cycle, drop any high phi within the same clk period; after release, leave IDLE no earlier than the first rising edge sampling a start condition.

Verification
REQ-030 Defaults, rst released, mode=0, active=1 sampled at edge T -> phi[0]=1 cycles T+1..T+8; phi=0 T+9..T+10; phi[1]=1 T+11..T+18; phi=0 T+19..T+20; phi[0]=1 and cycle_start=1 at T+21; cycle_count=1 at T+21.
REQ-031 Free-run, active dropped during phi[0] of cycle 3 -> cycle 3 completes fully; busy=0 afterwards; cycle_count=3; phi stays 0.
REQ-032 mode=1, single step pulse -> exactly one 20-clk cycle, cycle_count +1, then IDLE; a second step pulse during busy -> no extra cycle.
REQ-033 NPHASE=4, HIGH_LEN=3, GAP_LEN=1 -> period 16; phi[0..3] each high 3 clks in order; onehot-or-zero phi checked every clk.
REQ-034 rst asserted while phi[1]=1 -> phi=0, busy=0, cycle_count=0 before the next clk edge; restart matches REQ-030 timing.
REQ-035 CNT_W=4, 17 free-run cycles -> cycle_count sequence wraps 15 -> 0 -> 1, generation uninterrupted.
